// File: rtl/pfb_frame_reorder.sv
// Ping-pong frame buffer that realigns polyphase filter-bank output frames to
// upstream tlast and optionally swaps the two half-frames on readout.
module pfb_frame_reorder #(
    parameter int N     = 32,
    parameter int L     = 4,
    parameter int SHIFT = 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic [2*L*32-1:0] s_axis_tdata,
    input  logic              m_axis_tready,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    output logic [2*L*32-1:0] m_axis_tdata,
    output logic              ovf,
    output logic              sync_err
);
    localparam int W  = 2 * L * 32;
    localparam int NB = N / (2 * L);
    localparam int AW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NB - 1);
    localparam logic [AW-1:0] HALF_IDX = AW'(NB / 2);

    typedef enum logic [1:0] {W_ALIGN, W_FILL, W_DROP} wstate_t;
    typedef enum logic {R_IDLE, R_RUN} rstate_t;

    logic [W-1:0]  mem_q [0:2*NB-1];

    wstate_t       wstate_q;
    logic [AW-1:0] wcnt_q;
    logic          wbank_q;
    logic [1:0]    full_q;
    logic [1:0]    full_d;
    logic          ovf_q;
    logic          sync_err_q;

    rstate_t       rstate_q;
    logic [AW-1:0] rcnt_q;
    logic          rbank_q;
    logic [W-1:0]  pf_data_q;
    logic          pf_valid_q;
    logic          pf_last_q;
    logic [W-1:0]  out_data_q;
    logic          out_valid_q;
    logic          out_last_q;

    logic          wr_accept;
    logic          commit;
    logic          out_ready;
    logic          fetch;
    logic          release_bank;
    logic [AW-1:0] rd_idx;

    // A beat is stored unless it is the first beat of a frame aimed at a bank still held by the reader.
    assign wr_accept    = s_axis_tvalid && (wstate_q == W_FILL) &&
                          !((wcnt_q == '0) && full_q[wbank_q]);
    assign commit       = wr_accept && s_axis_tlast && (wcnt_q == LAST_IDX);
    assign out_ready    = !out_valid_q || m_axis_tready;
    assign fetch        = full_q[rbank_q] && (!pf_valid_q || out_ready);
    assign release_bank = fetch && (rcnt_q == LAST_IDX);
    assign rd_idx       = (SHIFT != 0) ? (rcnt_q ^ HALF_IDX) : rcnt_q;

    always_comb begin
        full_d = full_q;
        if (commit) full_d[wbank_q] = 1'b1;
        if (release_bank) full_d[rbank_q] = 1'b0;
    end

    always_ff @(posedge aclk) begin
        if (wr_accept) mem_q[{wbank_q, wcnt_q}] <= s_axis_tdata;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wstate_q   <= W_ALIGN;
            wcnt_q     <= '0;
            wbank_q    <= 1'b0;
            full_q     <= 2'b00;
            ovf_q      <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (commit) wbank_q <= ~wbank_q;
            if (s_axis_tvalid) begin
                unique case (wstate_q)
                    W_ALIGN: begin
                        if (s_axis_tlast) begin
                            wstate_q <= W_FILL;
                            wcnt_q   <= '0;
                        end
                    end
                    W_FILL: begin
                        if ((wcnt_q == '0) && full_q[wbank_q]) begin
                            ovf_q    <= 1'b1;
                            wstate_q <= s_axis_tlast ? W_FILL : W_DROP;
                        end else if (s_axis_tlast) begin
                            if (wcnt_q != LAST_IDX) sync_err_q <= 1'b1;
                            wcnt_q <= '0;
                        end else if (wcnt_q == LAST_IDX) begin
                            sync_err_q <= 1'b1;
                            wcnt_q     <= '0;
                            wstate_q   <= W_ALIGN;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                    W_DROP: begin
                        if (s_axis_tlast) begin
                            wstate_q <= W_FILL;
                            wcnt_q   <= '0;
                        end
                    end
                    default: wstate_q <= W_ALIGN;
                endcase
            end
        end
    end

    // Prefetch register plus output register: the bank is drained one beat ahead of the
    // output, so a bank is released early enough for back-to-back frames.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rstate_q    <= R_IDLE;
            rcnt_q      <= '0;
            rbank_q     <= 1'b0;
            pf_data_q   <= '0;
            pf_valid_q  <= 1'b0;
            pf_last_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            if (out_ready) begin
                out_valid_q <= pf_valid_q;
                out_data_q  <= pf_data_q;
                out_last_q  <= pf_last_q;
            end
            if (fetch) begin
                pf_valid_q <= 1'b1;
                pf_data_q  <= mem_q[{rbank_q, rd_idx}];
                pf_last_q  <= (rcnt_q == LAST_IDX);
                if (rcnt_q == LAST_IDX) begin
                    rcnt_q   <= '0;
                    rbank_q  <= ~rbank_q;
                    rstate_q <= full_q[~rbank_q] ? R_RUN : R_IDLE;
                end else begin
                    rcnt_q   <= rcnt_q + 1'b1;
                    rstate_q <= R_RUN;
                end
            end else if (out_ready) begin
                pf_valid_q <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tdata  = out_data_q;
    assign ovf           = ovf_q;
    assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_pfb_frame_reorder.sv
// Directed bench for pfb_frame_reorder (N=32, L=4, SHIFT=1): cycle table for the
// first frame, then scoreboarded sequences for overflow, sync and reset cases.
module tb_pfb_frame_reorder;
    localparam int N  = 32;
    localparam int L  = 4;
    localparam int W  = 2 * L * 32;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic [W-1:0] s_axis_tdata = '0;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic [W-1:0] m_axis_tdata;
    logic         ovf;
    logic         sync_err;

    pfb_frame_reorder #(.N(N), .L(L), .SHIFT(1)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast),
        .s_axis_tdata(s_axis_tdata),
        .m_axis_tready(m_axis_tready),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tdata(m_axis_tdata),
        .ovf(ovf),
        .sync_err(sync_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        logic v;
        logic l;
        int   tag;
        int   beat;
        logic expV;
        logic expL;
        int   expBeat;
    } vec_t;

    beat_t expQ[$];
    vec_t  vecs[14];
    int    checks = 0;
    int    passes = 0;
    int    cycle = 0;
    int    xferCount = 0;
    int    firstXfer = 0;
    int    lastXfer = 0;
    int    validSeen = 0;
    bit    scoreOn = 1'b0;

    function automatic logic [W-1:0] mkBeat(input int tag, input int beat);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < 2 * L; i++) begin
            r[i*32 +: 32] = {8'hA5, tag[7:0], beat[7:0], i[7:0]};
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one beat, score any transfer happening at the coming edge, then advance a cycle.
    task automatic applyStimulus(input logic v, input logic l, input logic [W-1:0] d);
        beat_t b;
        s_axis_tvalid = v;
        s_axis_tlast  = l;
        s_axis_tdata  = d;
        #1;
        if (m_axis_tvalid) validSeen++;
        if (scoreOn && m_axis_tvalid && m_axis_tready) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected beat: got %0h expected no beat", m_axis_tdata);
            end else begin
                b = expQ.pop_front();
                checkOutput("beat data", m_axis_tdata, b.data);
                checkOutput("beat last", W'(m_axis_tlast), W'(b.last));
            end
            if (xferCount == 0) firstXfer = cycle;
            lastXfer = cycle;
            xferCount++;
        end
        @(posedge aclk);
        #1;
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0);
    endtask

    task automatic sendFrame(input int tag, input int nbeats, input int lastPos);
        for (int b = 0; b < nbeats; b++) applyStimulus(1'b1, b == lastPos, mkBeat(tag, b));
    endtask

    task automatic pushFrame(input int tag);
        int order[4] = '{2, 3, 0, 1};
        beat_t b;
        for (int k = 0; k < 4; k++) begin
            b.data = mkBeat(tag, order[k]);
            b.last = (k == 3);
            expQ.push_back(b);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 200) begin
            applyStimulus(1'b0, 1'b0, '0);
            n++;
        end
        checks++;
        if (expQ.size() == 0) passes++;
        else $display("[TB] FAIL %s drain: got %0d beats left expected 0", name, expQ.size());
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 'hEE, 0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 'hEE, 1, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b0, 'hEE, 2, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b1, 1'b1, 'hEE, 3, 1'b0, 1'b0, 0};
        vecs[4]  = '{1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 0};
        vecs[5]  = '{1'b1, 1'b0, 1, 1, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b1, 1'b0, 1, 2, 1'b0, 1'b0, 0};
        vecs[7]  = '{1'b1, 1'b1, 1, 3, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 2};
        vecs[10] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 3};
        vecs[11] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 0};
        vecs[12] = '{1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1};
        vecs[13] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0};

        aresetn = 1'b0;
        idle(2);
        checkOutput("reset tvalid", W'(m_axis_tvalid), '0);
        checkOutput("reset tlast", W'(m_axis_tlast), '0);
        checkOutput("reset tdata", m_axis_tdata, '0);
        checkOutput("reset ovf", W'(ovf), '0);
        checkOutput("reset sync_err", W'(sync_err), '0);
        aresetn = 1'b1;

        // Alignment junk, one frame, and its swapped readout, cycle by cycle.
        m_axis_tready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].v, vecs[i].l,
                          vecs[i].v ? mkBeat(vecs[i].tag, vecs[i].beat) : '0);
            checkOutput($sformatf("vec%0d tvalid", i), W'(m_axis_tvalid), W'(vecs[i].expV));
            if (vecs[i].expV) begin
                checkOutput($sformatf("vec%0d tlast", i), W'(m_axis_tlast), W'(vecs[i].expL));
                checkOutput($sformatf("vec%0d tdata", i), m_axis_tdata, mkBeat(1, vecs[i].expBeat));
            end
        end
        checkOutput("vec ovf", W'(ovf), '0);
        checkOutput("vec sync_err", W'(sync_err), '0);

        // Ten back-to-back frames must come out as one unbroken 40-beat stream.
        scoreOn = 1'b1;
        xferCount = 0;
        for (int f = 0; f < 10; f++) pushFrame(10 + f);
        for (int f = 0; f < 10; f++) sendFrame(10 + f, 4, 3);
        drain("b2b");
        checkOutput("b2b count", W'(xferCount), W'(40));
        checkOutput("b2b contiguous", W'(lastXfer - firstXfer + 1), W'(40));
        checkOutput("b2b ovf", W'(ovf), '0);
        checkOutput("b2b sync_err", W'(sync_err), '0);

        // Stalled output: third frame finds both banks full and is dropped.
        m_axis_tready = 1'b0;
        pushFrame(21);
        pushFrame(22);
        sendFrame(21, 4, 3);
        sendFrame(22, 4, 3);
        sendFrame(23, 4, 3);
        checkOutput("stall ovf", W'(ovf), W'(1));
        idle(3);
        checkOutput("stall tvalid", W'(m_axis_tvalid), W'(1));
        checkOutput("stall tdata", m_axis_tdata, mkBeat(21, 2));
        checkOutput("stall tlast", W'(m_axis_tlast), '0);
        m_axis_tready = 1'b1;
        drain("stall");
        pushFrame(24);
        sendFrame(24, 4, 3);
        drain("after drop");
        checkOutput("after drop sync_err", W'(sync_err), '0);

        // Early tlast on beat 2.
        checkOutput("pre short sync_err", W'(sync_err), '0);
        sendFrame(30, 3, 2);
        checkOutput("short sync_err", W'(sync_err), W'(1));
        pushFrame(31);
        sendFrame(31, 4, 3);
        drain("after short");

        // Missing tlast on beat 3, from a clean reset.
        aresetn = 1'b0;
        idle(1);
        aresetn = 1'b1;
        checkOutput("reset2 sync_err", W'(sync_err), '0);
        checkOutput("reset2 ovf", W'(ovf), '0);
        applyStimulus(1'b1, 1'b1, mkBeat('hEE, 0));
        sendFrame(40, 4, -1);
        checkOutput("long sync_err", W'(sync_err), W'(1));
        applyStimulus(1'b1, 1'b0, mkBeat('hEE, 1));
        applyStimulus(1'b1, 1'b0, mkBeat('hEE, 2));
        applyStimulus(1'b1, 1'b1, mkBeat('hEE, 3));
        pushFrame(41);
        sendFrame(41, 4, 3);
        drain("after long");

        // Reset while the second beat of a frame is presented.
        scoreOn = 1'b0;
        sendFrame(50, 4, 3);
        idle(2);
        checkOutput("mid tvalid", W'(m_axis_tvalid), W'(1));
        checkOutput("mid tdata0", m_axis_tdata, mkBeat(50, 2));
        idle(1);
        checkOutput("mid tdata1", m_axis_tdata, mkBeat(50, 3));
        aresetn = 1'b0;
        idle(1);
        aresetn = 1'b1;
        checkOutput("mid reset tvalid", W'(m_axis_tvalid), '0);
        checkOutput("mid reset tlast", W'(m_axis_tlast), '0);
        checkOutput("mid reset tdata", m_axis_tdata, '0);
        checkOutput("mid reset ovf", W'(ovf), '0);
        checkOutput("mid reset sync_err", W'(sync_err), '0);
        scoreOn = 1'b1;
        validSeen = 0;
        sendFrame(51, 4, 3);
        idle(8);
        checkOutput("realign no output", W'(validSeen), '0);
        pushFrame(52);
        sendFrame(52, 4, 3);
        drain("after reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
